// File: rtl/pwm_ramp_ctrl.sv
// PWM soft-start/soft-stop controller.
// Slews the applied duty one step per period toward a commanded target.
module pwm_ramp_ctrl #(
  parameter int BITS   = 8,
  parameter int PERIOD = 100,
  parameter int STEP   = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CMD_VALID,
  output logic            CMD_READY,
  input  logic            CMD_EN,
  input  logic [BITS-1:0] CMD_DUTY,
  output logic [BITS-1:0] DUTY_CUR,
  output logic            PERIOD_START,
  output logic            BUSY,
  output logic            OUTPUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_HOLD,
    S_STOP
  } state_t;

  localparam int W1 = BITS + 1;
  localparam logic [BITS-1:0] PER_V  = BITS'(PERIOD);
  localparam logic [BITS-1:0] LAST_V = BITS'(PERIOD - 1);
  localparam logic [W1-1:0]   STEP_V = W1'(STEP);

  state_t          state_q;
  logic [BITS-1:0] cnt_q;
  logic [BITS-1:0] duty_q;
  logic [BITS-1:0] tgt_q;
  logic            out_q;

  logic [BITS-1:0] cmd_tgt;
  logic            cmd_run;
  logic            accept;
  logic            bound;
  logic [W1-1:0]   cur_w;
  logic [W1-1:0]   tgt_w;
  logic [W1-1:0]   up_w;
  logic [BITS-1:0] first_d;
  logic [BITS-1:0] step_d;

  // Target is clamped to the period; a zero run target means disable.
  assign cmd_tgt = (CMD_DUTY > PER_V) ? PER_V : CMD_DUTY;
  assign cmd_run = CMD_EN && (cmd_tgt != '0);

  assign CMD_READY = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign accept    = CMD_VALID && CMD_READY;
  assign bound     = (state_q != S_IDLE) && (cnt_q == LAST_V);

  assign cur_w = {1'b0, duty_q};
  assign tgt_w = {1'b0, tgt_q};
  assign up_w  = cur_w + STEP_V;

  assign first_d = (STEP_V >= {1'b0, cmd_tgt})
                 ? cmd_tgt : STEP_V[BITS-1:0];

  // Duty for the next period: one step toward target, saturating.
  always_comb begin
    step_d = duty_q;
    if (duty_q < tgt_q) begin
      step_d = (up_w >= tgt_w) ? tgt_q : up_w[BITS-1:0];
    end else if (duty_q > tgt_q) begin
      step_d = (cur_w <= tgt_w + STEP_V)
             ? tgt_q : duty_q - STEP_V[BITS-1:0];
    end
  end

  // Control FSM, period counter, duty slew and PWM output register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      out_q <= (state_q != S_IDLE) && (cnt_q < duty_q);
      if (state_q == S_IDLE) begin
        cnt_q <= '0;
        if (accept && cmd_run) begin
          tgt_q   <= cmd_tgt;
          duty_q  <= first_d;
          state_q <= (first_d == cmd_tgt) ? S_HOLD : S_RAMP;
        end
      end else begin
        cnt_q <= bound ? '0 : cnt_q + 1'b1;
        if (bound) begin
          duty_q <= step_d;
        end
        case (state_q)
          S_RAMP: begin
            if (bound && (step_d == tgt_q)) begin
              state_q <= S_HOLD;
            end
          end
          S_STOP: begin
            if (bound && (step_d == '0)) begin
              state_q <= S_IDLE;
            end
          end
          S_HOLD: begin
            if (accept) begin
              if (!cmd_run) begin
                tgt_q   <= '0;
                state_q <= S_STOP;
              end else begin
                tgt_q   <= cmd_tgt;
                state_q <= (cmd_tgt == duty_q) ? S_HOLD : S_RAMP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign DUTY_CUR     = duty_q;
  assign OUTPUT       = out_q;
  assign PERIOD_START = (state_q != S_IDLE) && (cnt_q == '0);
  assign BUSY         = (state_q == S_RAMP) || (state_q == S_STOP);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl (BITS=4, PERIOD=10, STEP=2).
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_pwm_ramp_ctrl;

  logic       CLK;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic       CMD_EN;
  logic [3:0] CMD_DUTY;
  logic [3:0] DUTY_CUR;
  logic       PERIOD_START;
  logic       BUSY;
  logic       OUTPUT;

  pwm_ramp_ctrl #(
    .BITS  (4),
    .PERIOD(10),
    .STEP  (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CMD_VALID   (CMD_VALID),
    .CMD_READY   (CMD_READY),
    .CMD_EN      (CMD_EN),
    .CMD_DUTY    (CMD_DUTY),
    .DUTY_CUR    (DUTY_CUR),
    .PERIOD_START(PERIOD_START),
    .BUSY        (BUSY),
    .OUTPUT      (OUTPUT)
  );

  typedef struct {
    int    cyc;
    bit    rdy;
    bit    busy;
    bit    out;
    bit    ps;
    int    duty;
    string tag;
  } snap_t;

  typedef struct {
    int duty;
    int hi;
  } per_t;

  snap_t sq[$];
  per_t  pq[$];
  snap_t s;
  per_t  p;

  int cyc    = 0;
  int checks = 0;
  int passes = 0;
  bit win    = 0;
  int n      = 0;
  int hi     = 0;
  int exp_hi = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  // Monitor: snapshot checks by cycle, then per-period duty/high-time.
  always @(negedge CLK) begin
    while (sq.size() > 0 && sq[0].cyc == cyc) begin
      s = sq.pop_front();
      chk({s.tag, ".ready"}, 32'(CMD_READY), 32'(s.rdy));
      chk({s.tag, ".busy"}, 32'(BUSY), 32'(s.busy));
      chk({s.tag, ".output"}, 32'(OUTPUT), 32'(s.out));
      chk({s.tag, ".pstart"}, 32'(PERIOD_START), 32'(s.ps));
      chk({s.tag, ".duty"}, 32'(DUTY_CUR), 32'(s.duty));
    end
    if (RST === 1'b1) begin
      win = 0;
    end else begin
      if (win) begin
        if (OUTPUT === 1'b1) hi++;
        n++;
        if (n == 10) begin
          chk("period_high_time", 32'(hi), 32'(exp_hi));
          win = 0;
        end
      end
      if (PERIOD_START === 1'b1) begin
        if (win) chk("period_spacing", 32'(n), 32'd10);
        if (pq.size() == 0) begin
          chk("unexpected_period", 32'd1, 32'd0);
          exp_hi = -1;
        end else begin
          p = pq.pop_front();
          chk("period_duty", 32'(DUTY_CUR), 32'(p.duty));
          exp_hi = p.hi;
        end
        win = 1;
        hi  = 0;
        n   = 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(int k);
    repeat (k) tick();
  endtask

  task automatic snap(string t, bit rdy, bit busy, bit out, bit ps,
                      int duty);
    snap_t e;
    e.cyc  = cyc;
    e.rdy  = rdy;
    e.busy = busy;
    e.out  = out;
    e.ps   = ps;
    e.duty = duty;
    e.tag  = t;
    sq.push_back(e);
  endtask

  task automatic per(int duty, int h);
    per_t e;
    e.duty = duty;
    e.hi   = h;
    pq.push_back(e);
  endtask

  task automatic cmd(bit v, bit en, int d);
    CMD_VALID = v;
    CMD_EN    = en;
    CMD_DUTY  = 4'(d);
  endtask

  initial begin
    RST = 1'b1;
    cmd(0, 0, 0);
    ticks(3);
    snap("reset", 1, 0, 0, 0, 0);
    RST = 1'b0;
    tick();
    snap("idle", 1, 0, 0, 0, 0);

    // Ramp 0 -> 3 : first duty 2, then 3.
    per(2, 2); per(3, 3); per(3, 3);
    cmd(1, 1, 3);
    tick();
    cmd(0, 0, 0);
    snap("t1_accept", 0, 1, 0, 1, 2);
    tick();
    snap("t1_first_high", 0, 1, 1, 0, 2);
    ticks(8);
    snap("t1_pre_bound", 0, 1, 0, 0, 2);
    tick();
    snap("t1_hold", 1, 0, 0, 1, 3);

    // Hold 3 -> 9 in steps 5,7,9.
    ticks(14);
    per(5, 5); per(7, 7); per(9, 9);
    cmd(1, 1, 9);
    tick();
    cmd(0, 0, 0);
    snap("t2_accept", 0, 1, 0, 0, 3);
    ticks(24);
    snap("t2_busy", 0, 1, 0, 0, 7);
    tick();
    snap("t2_hold", 1, 0, 0, 1, 9);

    // Disable: 9 -> 7,5,3,1,0 then idle.
    ticks(4);
    per(7, 7); per(5, 5); per(3, 3); per(1, 1);
    cmd(1, 0, 0);
    tick();
    cmd(0, 0, 0);
    snap("t3_accept", 0, 1, 1, 0, 9);
    ticks(44);
    snap("t3_last", 0, 1, 0, 0, 1);
    tick();
    snap("t3_idle", 1, 0, 0, 0, 0);
    ticks(5);
    snap("t3_quiet", 1, 0, 0, 0, 0);

    // In idle, disable and zero-duty run are both ignored.
    cmd(1, 0, 5);
    tick();
    snap("idle_en0", 1, 0, 0, 0, 0);
    cmd(1, 1, 0);
    tick();
    snap("idle_duty0", 1, 0, 0, 0, 0);

    // Duty 15 clamps to 10: ramp 2,4,6,8,10 then full-on.
    per(2, 2); per(4, 4); per(6, 6); per(8, 8);
    per(10, 10); per(10, 10); per(10, 10); per(8, 8);
    cmd(1, 1, 15);
    tick();
    cmd(0, 0, 0);
    snap("t4_accept", 0, 1, 0, 1, 2);
    ticks(40);
    snap("t4_hold", 1, 0, 0, 1, 10);
    ticks(5);
    snap("t4_full_on", 1, 0, 1, 0, 10);

    // Command on a boundary edge in hold: duty unchanged, ramp down.
    ticks(14);
    cmd(1, 1, 4);
    tick();
    cmd(0, 0, 0);
    snap("t5_accept", 0, 1, 1, 1, 10);
    ticks(14);
    snap("t5_mid_ramp", 0, 1, 1, 0, 8);

    // Reset at count 4 with a command held valid.
    RST = 1'b1;
    cmd(1, 1, 5);
    tick();
    snap("t5_reset", 1, 0, 0, 0, 0);
    tick();
    snap("t5_reset2", 1, 0, 0, 0, 0);
    RST = 1'b0;
    cmd(0, 0, 0);
    tick();
    snap("t5_no_accept", 1, 0, 0, 0, 0);

    // Valid held through ramp: accepted on the edge after hold.
    per(2, 2); per(4, 4); per(5, 5); per(3, 3); per(1, 1);
    cmd(1, 1, 5);
    tick();
    cmd(1, 1, 1);
    snap("t6_accept", 0, 1, 0, 1, 2);
    ticks(19);
    snap("t6_waiting", 0, 1, 0, 0, 4);
    tick();
    snap("t6_hold", 1, 0, 0, 1, 5);
    tick();
    cmd(0, 0, 0);
    snap("t6_accept2", 0, 1, 1, 0, 5);
    tick();
    snap("t6_single", 0, 1, 1, 0, 5);
    ticks(18);
    snap("t6_hold2", 1, 0, 0, 1, 1);
    ticks(4);
    cmd(1, 0, 0);
    tick();
    cmd(0, 0, 0);
    snap("t6_stop", 0, 1, 0, 0, 1);
    ticks(5);
    snap("t6_idle", 1, 0, 0, 0, 0);
    ticks(12);

    chk("periods_left", 32'(pq.size()), 32'd0);
    chk("snaps_left", 32'(sq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
